// File: rtl/piso_tx_scheduler.sv
// rtl/piso_tx_scheduler.sv - round-robin scheduler feeding one shared parallel-to-serial shifter
// A frame is one LOAD cycle, WIDTH-1 SHIFT cycles and GAP idle cycles; the next winner is picked at frame end.
module piso_tx_scheduler #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int GAP   = 0,
  localparam int ID_W = $clog2(N_REQ),
  localparam int BC_W = $clog2(WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   load,
  output logic [WIDTH-1:0]       parallel_in,
  output logic                   busy,
  output logic [ID_W-1:0]        grant_id,
  output logic [BC_W-1:0]        bit_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_GAP} state_t;

  localparam logic [BC_W-1:0] BIT_LAST = BC_W'(WIDTH - 1);
  localparam logic [3:0]      GAP_LAST = 4'((GAP == 0) ? 0 : GAP - 1);

  state_t                 state_q, state_d;
  logic [ID_W-1:0]        rr_q, rr_d;
  logic [ID_W-1:0]        grant_id_q, grant_id_d;
  logic [BC_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [3:0]             gap_cnt_q, gap_cnt_d;
  logic                   load_q, load_d;
  logic                   busy_q, busy_d;
  logic [N_REQ-1:0]       req_ready_q, req_ready_d;
  logic [WIDTH-1:0]       parallel_in_q, parallel_in_d;

  logic [WIDTH-1:0]       words [N_REQ];
  logic [ID_W-1:0]        win;
  logic                   found;
  logic [ID_W:0]          sum;
  logic [ID_W-1:0]        idx;
  logic                   frame_end;
  logic                   start;

  for (genvar g = 0; g < N_REQ; g++) begin : g_words
    assign words[g] = req_data[g*WIDTH +: WIDTH];
  end

  // First valid requester at or after the pointer, wrapping past N_REQ-1.
  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sum = {1'b0, rr_q} + (ID_W+1)'(i);
      if (sum >= (ID_W+1)'(N_REQ)) sum = sum - (ID_W+1)'(N_REQ);
      idx = sum[ID_W-1:0];
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    frame_end = ((state_q == S_SHIFT) && (bit_cnt_q == BIT_LAST) && (GAP == 0)) ||
                ((state_q == S_GAP) && (gap_cnt_q == GAP_LAST));
    start     = en && found && ((state_q == S_IDLE) || frame_end);

    state_d       = state_q;
    rr_d          = rr_q;
    grant_id_d    = grant_id_q;
    bit_cnt_d     = bit_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    parallel_in_d = parallel_in_q;
    req_ready_d   = '0;
    load_d        = 1'b0;

    case (state_q)
      S_IDLE: ;
      S_LOAD: begin
        state_d   = S_SHIFT;
        bit_cnt_d = BC_W'(1);
      end
      S_SHIFT: begin
        if (bit_cnt_q == BIT_LAST) begin
          if (GAP > 0) begin
            state_d   = S_GAP;
            gap_cnt_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + BC_W'(1);
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = S_IDLE;
        else gap_cnt_d = gap_cnt_q + 4'd1;
      end
      default: state_d = S_IDLE;
    endcase

    // A grant overrides the frame-end return to IDLE so frames run back to back.
    if (start) begin
      state_d       = S_LOAD;
      rr_d          = (win == ID_W'(N_REQ - 1)) ? '0 : win + ID_W'(1);
      grant_id_d    = win;
      parallel_in_d = words[win];
      req_ready_d   = N_REQ'(1) << win;
      load_d        = 1'b1;
      bit_cnt_d     = '0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      rr_q          <= '0;
      grant_id_q    <= '0;
      bit_cnt_q     <= '0;
      gap_cnt_q     <= '0;
      load_q        <= 1'b0;
      busy_q        <= 1'b0;
      req_ready_q   <= '0;
      parallel_in_q <= '0;
    end else begin
      state_q       <= state_d;
      rr_q          <= rr_d;
      grant_id_q    <= grant_id_d;
      bit_cnt_q     <= bit_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      load_q        <= load_d;
      busy_q        <= busy_d;
      req_ready_q   <= req_ready_d;
      parallel_in_q <= parallel_in_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign load        = load_q;
  assign parallel_in = parallel_in_q;
  assign busy        = busy_q;
  assign grant_id    = grant_id_q;
  assign bit_cnt     = bit_cnt_q;

endmodule

// File: tb/tb_piso_tx_scheduler.sv
// tb/tb_piso_tx_scheduler.sv - scoreboard bench for piso_tx_scheduler (GAP=0 and GAP=3 instances)
module tb_piso_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst_a, rst_b, en;
  logic [3:0]  req_valid;
  logic [31:0] req_data;

  logic [3:0]  ready_a, ready_b;
  logic        load_a, load_b, busy_a, busy_b;
  logic [7:0]  pin_a, pin_b;
  logic [1:0]  gid_a, gid_b;
  logic [2:0]  bc_a, bc_b;

  logic        use_b;
  logic [3:0]  o_ready;
  logic        o_load, o_busy;
  logic [7:0]  o_pin;
  logic [1:0]  o_gid;
  logic [2:0]  o_bc;

  logic [7:0]  sh;
  logic [9:0]  sb [$];
  logic [9:0]  exp_e;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc;
  bit          ok, saw_idle;

  localparam logic [31:0] WORDS = {8'h0F, 8'hA5, 8'h96, 8'h3C};

  always #5 clk = ~clk;

  piso_tx_scheduler #(.N_REQ(4), .WIDTH(8), .GAP(0)) u_g0 (
    .clk(clk), .rst(rst_a), .en(en), .req_valid(req_valid), .req_data(req_data),
    .req_ready(ready_a), .load(load_a), .parallel_in(pin_a), .busy(busy_a),
    .grant_id(gid_a), .bit_cnt(bc_a));

  piso_tx_scheduler #(.N_REQ(4), .WIDTH(8), .GAP(3)) u_g3 (
    .clk(clk), .rst(rst_b), .en(en), .req_valid(req_valid), .req_data(req_data),
    .req_ready(ready_b), .load(load_b), .parallel_in(pin_b), .busy(busy_b),
    .grant_id(gid_b), .bit_cnt(bc_b));

  always_comb begin
    o_ready = use_b ? ready_b : ready_a;
    o_load  = use_b ? load_b  : load_a;
    o_busy  = use_b ? busy_b  : busy_a;
    o_pin   = use_b ? pin_b   : pin_a;
    o_gid   = use_b ? gid_b   : gid_a;
    o_bc    = use_b ? bc_b    : bc_a;
  end

  // Reference shifter: captures on the load edge, then emits MSB first.
  always @(posedge clk or negedge rst_a) begin
    if (!rst_a) sh <= '0;
    else if (load_a) sh <= pin_a;
    else sh <= {sh[6:0], 1'b0};
  end

  function automatic logic [9:0] entry(input logic [1:0] id);
    logic [31:0] w;
    w = WORDS;
    return {id, w[id*8 +: 8]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_load(input int max, output int c, output bit got, output bit idle);
    c = 0; got = 0; idle = 0;
    while (c < max && !got) begin
      tick();
      c++;
      if (o_load) got = 1;
      else if (!o_busy) idle = 1;
    end
  endtask

  task automatic pop_exp();
    if (sb.size() != 0) exp_e = sb.pop_front();
    else exp_e = '1;
  endtask

  task automatic test_reset();
    use_b = 0; rst_a = 0; rst_b = 0;
    en = 1'($urandom); req_valid = 4'($urandom); req_data = $urandom;
    repeat (3) tick();
    n_tests++; if (load_a !== 1'b0) begin n_fail++; $display("FAIL reset_load: got %b want 0", load_a); end
    n_tests++; if (ready_a !== 4'h0) begin n_fail++; $display("FAIL reset_ready: got %h want 0", ready_a); end
    n_tests++; if (pin_a !== 8'h00) begin n_fail++; $display("FAIL reset_pin: got %h want 0", pin_a); end
    n_tests++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_a); end
    n_tests++; if (gid_a !== 2'd0) begin n_fail++; $display("FAIL reset_gid: got %0d want 0", gid_a); end
    n_tests++; if (bc_a !== 3'd0) begin n_fail++; $display("FAIL reset_bitcnt: got %0d want 0", bc_a); end
    req_valid = 4'h0; req_data = WORDS; en = 1; rst_a = 1;
    repeat (2) tick();
    n_tests++;
    if ({load_a, busy_a} !== 2'b00) begin
      n_fail++; $display("FAIL reset_idle: got load,busy=%b want 00", {load_a, busy_a});
    end
  endtask

  task automatic test_single();
    logic [7:0] ser;
    req_valid = 4'b0100;
    sb.push_back(entry(2'd2));
    wait_load(20, cyc, ok, saw_idle);
    pop_exp();
    n_tests++; if (cyc !== 1) begin n_fail++; $display("FAIL single_latency: got %0d want 1", cyc); end
    n_tests++;
    if ({o_gid, o_ready, o_pin, o_bc, o_busy} !== {exp_e[9:8], 4'b0100, exp_e[7:0], 3'd0, 1'b1}) begin
      n_fail++; $display("FAIL single_load: got gid=%0d rdy=%b pin=%h bc=%0d busy=%b want gid=%0d rdy=0100 pin=%h bc=0 busy=1",
                         o_gid, o_ready, o_pin, o_bc, o_busy, exp_e[9:8], exp_e[7:0]);
    end
    ser = '0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 1) req_valid = 4'h0;
      ser = {ser[6:0], sh[7]};
      if (k <= 7) begin
        n_tests++;
        if ({o_busy, o_bc, o_load, o_ready} !== {1'b1, 3'(k), 1'b0, 4'h0}) begin
          n_fail++; $display("FAIL single_shift%0d: got busy=%b bc=%0d load=%b rdy=%b want 1 %0d 0 0000",
                             k, o_busy, o_bc, o_load, o_ready, k);
        end
      end else begin
        n_tests++;
        if ({o_busy, o_load} !== 2'b00) begin
          n_fail++; $display("FAIL single_end: got busy,load=%b want 00", {o_busy, o_load});
        end
      end
    end
    n_tests++; if (ser !== 8'hA5) begin n_fail++; $display("FAIL single_serial: got %h want a5", ser); end
  endtask

  task automatic test_round_robin();
    rst_a = 0; tick(); rst_a = 1;
    req_valid = 4'hF;
    for (int i = 0; i < 5; i++) sb.push_back(entry(2'(i % 4)));
    for (int n = 0; n < 5; n++) begin
      wait_load(20, cyc, ok, saw_idle);
      pop_exp();
      n_tests++;
      if ({cyc, saw_idle} !== {((n == 0) ? 1 : 8), 1'b0}) begin
        n_fail++; $display("FAIL rr_spacing%0d: got cyc=%0d idle=%b want cyc=%0d idle=0", n, cyc, saw_idle, (n == 0) ? 1 : 8);
      end
      n_tests++;
      if ({o_gid, o_ready, o_pin} !== {exp_e[9:8], 4'(1) << exp_e[9:8], exp_e[7:0]}) begin
        n_fail++; $display("FAIL rr_grant%0d: got gid=%0d rdy=%b pin=%h want gid=%0d pin=%h",
                           n, o_gid, o_ready, o_pin, exp_e[9:8], exp_e[7:0]);
      end
    end
    tick(); req_valid = 4'h0;
    repeat (10) tick();
    n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL rr_drain: got busy=%b want 0", o_busy); end
  endtask

  task automatic test_ptr_wrap();
    rst_a = 0; tick(); rst_a = 1;
    req_valid = 4'b0100;
    sb.push_back(entry(2'd2));
    wait_load(20, cyc, ok, saw_idle);
    pop_exp();
    n_tests++;
    if ({cyc, o_gid} !== {32'd1, exp_e[9:8]}) begin
      n_fail++; $display("FAIL wrap_setup: got cyc=%0d gid=%0d want 1 2", cyc, o_gid);
    end
    tick(); req_valid = 4'h0;
    repeat (9) tick();
    req_valid = 4'b0101;
    sb.push_back(entry(2'd0));
    sb.push_back(entry(2'd2));
    wait_load(20, cyc, ok, saw_idle);
    pop_exp();
    n_tests++;
    if ({cyc, o_gid, o_ready, o_pin} !== {32'd1, exp_e[9:8], 4'b0001, exp_e[7:0]}) begin
      n_fail++; $display("FAIL wrap_first: got cyc=%0d gid=%0d rdy=%b pin=%h want 1 0 0001 %h", cyc, o_gid, o_ready, o_pin, exp_e[7:0]);
    end
    tick(); req_valid = 4'b0100;
    wait_load(20, cyc, ok, saw_idle);
    pop_exp();
    n_tests++;
    if ({cyc, o_gid, o_ready, o_pin} !== {32'd7, exp_e[9:8], 4'b0100, exp_e[7:0]}) begin
      n_fail++; $display("FAIL wrap_second: got cyc=%0d gid=%0d rdy=%b pin=%h want 7 2 0100 %h", cyc, o_gid, o_ready, o_pin, exp_e[7:0]);
    end
    tick(); req_valid = 4'h0;
    repeat (9) tick();
  endtask

  task automatic test_en_abort();
    int  n;
    bit  extra;
    req_valid = 4'b0010; en = 1;
    sb.push_back(entry(2'd1));
    wait_load(20, cyc, ok, saw_idle);
    pop_exp();
    n_tests++;
    if ({cyc, o_gid, o_ready} !== {32'd1, exp_e[9:8], 4'b0010}) begin
      n_fail++; $display("FAIL en_first: got cyc=%0d gid=%0d rdy=%b want 1 1 0010", cyc, o_gid, o_ready);
    end
    tick(); en = 0;
    n = 0; extra = 0;
    while (o_busy && n < 20) begin tick(); n++; if (o_load) extra = 1; end
    n_tests++;
    if ({n, extra} !== {32'd7, 1'b0}) begin
      n_fail++; $display("FAIL en_finish: got cycles=%0d extra_load=%b want 7 0", n, extra);
    end
    extra = 0;
    repeat (3) begin tick(); if (o_load || o_busy) extra = 1; end
    n_tests++; if (extra !== 1'b0) begin n_fail++; $display("FAIL en_hold: got activity=%b want 0", extra); end
    en = 1;
    sb.push_back(entry(2'd1));
    wait_load(20, cyc, ok, saw_idle);
    pop_exp();
    n_tests++;
    if ({cyc, o_gid, o_pin} !== {32'd1, exp_e[9:8], exp_e[7:0]}) begin
      n_fail++; $display("FAIL en_resume: got cyc=%0d gid=%0d pin=%h want 1 1 %h", cyc, o_gid, o_pin, exp_e[7:0]);
    end
    n = 0;
    while (o_bc != 3'd4 && n < 10) begin tick(); n++; end
    n_tests++; if (n !== 4) begin n_fail++; $display("FAIL abort_reach: got %0d cycles want 4", n); end
    rst_a = 0;
    #1;
    n_tests++;
    if ({o_load, o_ready, o_busy, o_pin, o_gid, o_bc} !== 19'd0) begin
      n_fail++; $display("FAIL abort_outputs: got load=%b rdy=%b busy=%b pin=%h gid=%0d bc=%0d want all 0",
                         o_load, o_ready, o_busy, o_pin, o_gid, o_bc);
    end
    extra = 0;
    repeat (3) begin tick(); if (o_load || (o_ready != 4'h0)) extra = 1; end
    req_valid = 4'h0; rst_a = 1;
    repeat (3) begin tick(); if (o_load || (o_ready != 4'h0)) extra = 1; end
    n_tests++; if (extra !== 1'b0) begin n_fail++; $display("FAIL abort_no_ready: got activity=%b want 0", extra); end
  endtask

  task automatic test_back_to_back_gap();
    rst_a = 0; use_b = 1;
    req_valid = 4'b1010; en = 1; rst_b = 1;
    sb.push_back(entry(2'd1));
    sb.push_back(entry(2'd3));
    sb.push_back(entry(2'd1));
    for (int n = 0; n < 3; n++) begin
      wait_load(30, cyc, ok, saw_idle);
      pop_exp();
      n_tests++;
      if ({cyc, saw_idle} !== {((n == 0) ? 1 : 11), 1'b0}) begin
        n_fail++; $display("FAIL gap_spacing%0d: got cyc=%0d idle=%b want cyc=%0d idle=0", n, cyc, saw_idle, (n == 0) ? 1 : 11);
      end
      n_tests++;
      if ({o_gid, o_ready, o_pin} !== {exp_e[9:8], 4'(1) << exp_e[9:8], exp_e[7:0]}) begin
        n_fail++; $display("FAIL gap_grant%0d: got gid=%0d rdy=%b pin=%h want gid=%0d pin=%h",
                           n, o_gid, o_ready, o_pin, exp_e[9:8], exp_e[7:0]);
      end
    end
    tick(); req_valid = 4'h0;
    repeat (14) tick();
    n_tests++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL gap_drain: got busy=%b want 0", o_busy); end
    n_tests++; if (sb.size() !== 0) begin n_fail++; $display("FAIL scoreboard_left: got %0d entries want 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_ptr_wrap();
    test_en_abort();
    test_back_to_back_gap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
